// File: rtl/ram2e_cmd_pkg.sv
// Shared constants for the RAM2E select-register command path: unlock key,
// command codes and bus-phase markers used by the recognizer and the UFM stage.
package ram2e_cmd_pkg;

  localparam logic [7:0] KEY0 = 8'hFF;
  localparam logic [7:0] KEY1 = 8'h00;
  localparam logic [7:0] KEY2 = 8'h55;
  localparam logic [7:0] KEY3 = 8'hAA;
  localparam logic [7:0] KEY4 = 8'hC1;
  localparam logic [7:0] KEY5 = 8'hAD;

  localparam logic [7:0] CMD_LEDSET    = 8'h20;
  localparam logic [7:0] CMD_RWMASKSET = 8'h40;
  // UFM commands are decoded downstream while CS==6; listed here for reference.
  localparam logic [7:0] CMD_UFM_EA    = 8'hEA;
  localparam logic [7:0] CMD_UFM_EE    = 8'hEE;
  localparam logic [7:0] CMD_UFM_EF    = 8'hEF;

  localparam logic [3:0] S_QW   = 4'hC;
  localparam logic [3:0] S_TICK = 4'h0;

  localparam logic [2:0] CS_IDLE = 3'd0;
  localparam logic [2:0] CS_CMD  = 3'd6;
  localparam logic [2:0] CS_DATA = 3'd7;

  typedef struct packed {
    logic rwmask;
    logic led;
  } cmd_flags_t;

  function automatic logic [7:0] key_byte(input logic [2:0] pos);
    case (pos)
      3'd0:    key_byte = KEY0;
      3'd1:    key_byte = KEY1;
      3'd2:    key_byte = KEY2;
      3'd3:    key_byte = KEY3;
      3'd4:    key_byte = KEY4;
      3'd5:    key_byte = KEY5;
      default: key_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/ram2e_cmd_seq_if.sv
// Select-register bus view: phase, write qualifier and data in; sequence state out.
interface ram2e_cmd_seq_if;
  logic [3:0] S;
  logic       RWSel;
  logic [7:0] D;
  logic [2:0] CS;
  logic       CmdRWMaskSet;
  logic       CmdLEDSet;
  logic       SeqActive;

  modport master (output S, RWSel, D, input CS, CmdRWMaskSet, CmdLEDSet, SeqActive);
  modport slave  (input S, RWSel, D, output CS, CmdRWMaskSet, CmdLEDSet, SeqActive);
endinterface

// File: rtl/ram2e_seq_timer.sv
// Bus-cycle inactivity counter: counts S==0 ticks, clears on demand, and
// flags expiry on the tick where the count already equals SEQ_TIMEOUT.
module ram2e_seq_timer #(
  parameter int unsigned SEQ_TIMEOUT = 255
) (
  input  logic C14M,
  input  logic Rst,
  input  logic clr,
  input  logic tick,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(SEQ_TIMEOUT);

  logic [7:0] count;

  // Expiry returns the count to zero, so with LIMIT<=255 it can never wrap.
  assign expire = tick && !clr && (count == LIMIT);

  always_ff @(posedge C14M) begin
    if (Rst || clr) begin
      count <= 8'd0;
    end else if (tick) begin
      count <= expire ? 8'd0 : count + 8'd1;
    end
  end

endmodule

// File: rtl/ram2e_cmd_seq.sv
// RAMWorks select-register command recognizer: unlock key, command byte,
// data byte, with an inactivity timeout that aborts partial sequences.
module ram2e_cmd_seq
  import ram2e_cmd_pkg::*;
#(
  parameter int unsigned SEQ_TIMEOUT = 255
) (
  input  logic            C14M,
  input  logic            Rst,
  ram2e_cmd_seq_if.slave  bus
);

  logic [2:0] cs;
  cmd_flags_t flags;
  logic       qw;
  logic       tick;
  logic       expire;

  assign qw   = (bus.S == S_QW) && bus.RWSel;
  assign tick = (bus.S == S_TICK);

  ram2e_seq_timer #(
    .SEQ_TIMEOUT (SEQ_TIMEOUT)
  ) u_timer (
    .C14M   (C14M),
    .Rst    (Rst),
    .clr    (qw || (cs == CS_IDLE)),
    .tick   (tick),
    .expire (expire)
  );

  // NOTE: non-blocking updates are what let the downstream stage see the old
  // CS and flags on the same edge as the qualified write that changes them.
  always_ff @(posedge C14M) begin
    if (Rst) begin
      cs    <= CS_IDLE;
      flags <= '0;
    end else if (expire) begin
      cs    <= CS_IDLE;
      flags <= '0;
    end else if (qw) begin
      case (cs)
        CS_CMD: begin
          cs           <= CS_DATA;
          flags.led    <= (bus.D == CMD_LEDSET);
          flags.rwmask <= (bus.D == CMD_RWMASKSET);
        end
        CS_DATA: begin
          cs    <= CS_IDLE;
          flags <= '0;
        end
        default: begin
          // A stray FF is always a valid first key byte, so restart at 1.
          if (bus.D == key_byte(cs)) cs <= cs + 3'd1;
          else if (bus.D == KEY0)    cs <= 3'd1;
          else                       cs <= CS_IDLE;
        end
      endcase
    end
  end

  assign bus.CS           = cs;
  assign bus.CmdLEDSet    = flags.led;
  assign bus.CmdRWMaskSet = flags.rwmask;
  assign bus.SeqActive    = (cs != CS_IDLE);

endmodule

// File: tb/tb_ram2e_cmd_seq.sv
// Scoreboard bench for ram2e_cmd_seq: each bus cycle may queue the expected
// end-of-cycle state; a monitor pops and compares at the S==0 edge.
module tb_ram2e_cmd_seq;
  import ram2e_cmd_pkg::*;

  localparam int unsigned T = 10;

  typedef struct {
    logic [2:0] cs;
    logic       led;
    logic       mask;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  logic [7:0] ds_led;
  logic [8:0] ds_mask;
  int         ds_led_events  = 0;
  int         ds_mask_events = 0;

  ram2e_cmd_seq_if bus ();

  ram2e_cmd_seq #(
    .SEQ_TIMEOUT (T)
  ) dut (
    .C14M (clk),
    .Rst  (rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: expected state is compared just after each S==0 edge.
  always @(posedge clk) begin
    if (bus.S == S_TICK && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      #1;
      check(e.name,
            {26'd0, bus.SeqActive, bus.CmdRWMaskSet, bus.CmdLEDSet, bus.CS},
            {26'd0, (e.cs != 3'd0), e.mask, e.led, e.cs});
    end
  end

  // Output invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("seqactive_vs_cs", {31'd0, bus.SeqActive}, {31'd0, (bus.CS != 3'd0)});
      check("flags_only_in_cs7",
            {30'd0, bus.CmdLEDSet, bus.CmdRWMaskSet},
            (bus.CS == 3'd7) ? {30'd0, bus.CmdLEDSet, bus.CmdRWMaskSet} : 32'd0);
      check("flags_exclusive", {31'd0, bus.CmdLEDSet & bus.CmdRWMaskSet}, 32'd0);
    end
  end

  // Downstream model: consumes CS and flags as they stand on the QW edge.
  always @(posedge clk) begin
    if (!rst && bus.S == S_QW && bus.RWSel && bus.CS == 3'd7) begin
      if (bus.CmdLEDSet) begin
        ds_led = bus.D;
        ds_led_events++;
      end
      if (bus.CmdRWMaskSet) begin
        ds_mask = {1'b0, ~bus.D[6:0]};
        ds_mask_events++;
      end
    end
  end

  // One bus cycle with phases S=1..F,0; the write lands at S=C.
  task automatic bus_cycle(input logic sel, input logic [7:0] d, input logic chk,
                           input logic [2:0] ecs, input logic eled, input logic emask,
                           input logic rst_at_qw, input string name);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      bus.S     = 4'(i);
      bus.RWSel = sel;
      bus.D     = d;
      rst       = rst_at_qw && (i == 12);
      if (i == 16 && chk) begin
        exp_t e;
        e.cs   = ecs;
        e.led  = eled;
        e.mask = emask;
        e.name = name;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wr(input logic [7:0] d, input logic [2:0] ecs, input logic eled,
                    input logic emask, input string name);
    bus_cycle(1'b1, d, 1'b1, ecs, eled, emask, 1'b0, name);
  endtask

  task automatic idle(input logic [2:0] ecs, input string name);
    bus_cycle(1'b0, 8'h00, 1'b1, ecs, 1'b0, 1'b0, 1'b0, name);
  endtask

  task automatic key_to_cs4(input string name);
    wr(8'hFF, 3'd1, 1'b0, 1'b0, name);
    wr(8'h00, 3'd2, 1'b0, 1'b0, name);
    wr(8'h55, 3'd3, 1'b0, 1'b0, name);
    wr(8'hAA, 3'd4, 1'b0, 1'b0, name);
  endtask

  task automatic key_to_cs6(input string name);
    key_to_cs4(name);
    wr(8'hC1, 3'd5, 1'b0, 1'b0, name);
    wr(8'hAD, 3'd6, 1'b0, 1'b0, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    bus.S     = 4'h0;
    bus.RWSel = 1'b0;
    bus.D     = 8'h00;
    ds_led    = 8'hXX;
    ds_mask   = 9'h1FF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {26'd0, bus.SeqActive, bus.CmdRWMaskSet, bus.CmdLEDSet, bus.CS}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(3'd0, "idle_after_reset");

    // Full LED command.
    key_to_cs6("led_key");
    wr(8'h20, 3'd7, 1'b1, 1'b0, "led_cmd");
    wr(8'h01, 3'd0, 1'b0, 1'b0, "led_data");
    check("ds_led_events", ds_led_events, 1);
    check("ds_led_value", {24'd0, ds_led}, 32'h01);

    // Mask command.
    key_to_cs6("mask_key");
    wr(8'h40, 3'd7, 1'b0, 1'b1, "mask_cmd");
    wr(8'h7F, 3'd0, 1'b0, 1'b0, "mask_data");
    check("ds_mask_events", ds_mask_events, 1);
    check("ds_mask_value", {23'd0, ds_mask}, 32'h000);

    // Restart on FF, then mismatch to 0.
    wr(8'hFF, 3'd1, 1'b0, 1'b0, "restart_ff1");
    wr(8'h00, 3'd2, 1'b0, 1'b0, "restart_001");
    wr(8'hFF, 3'd1, 1'b0, 1'b0, "restart_ff2");
    wr(8'h00, 3'd2, 1'b0, 1'b0, "restart_002");
    wr(8'h55, 3'd3, 1'b0, 1'b0, "restart_55");
    wr(8'hFF, 3'd1, 1'b0, 1'b0, "mismatch_ff");
    wr(8'h00, 3'd2, 1'b0, 1'b0, "mismatch_00");
    wr(8'h12, 3'd0, 1'b0, 1'b0, "mismatch_12");

    // Timeout: T idle bus cycles from CS4 abort exactly at the T-th.
    key_to_cs4("to_key");
    for (int k = 1; k < int'(T); k++) idle(3'd4, "to_hold");
    idle(3'd0, "to_expire");

    // T-1 idle cycles, then C1 still continues; finish with unknown command EE.
    key_to_cs4("nt_key");
    for (int k = 1; k < int'(T); k++) idle(3'd4, "nt_hold");
    wr(8'hC1, 3'd5, 1'b0, 1'b0, "nt_c1");
    wr(8'hAD, 3'd6, 1'b0, 1'b0, "nt_ad");
    wr(8'hEE, 3'd7, 1'b0, 1'b0, "unk_cmd");
    wr(8'h00, 3'd0, 1'b0, 1'b0, "unk_data");

    // Reset at CS7 with the LED flag set; a QW of FF on that edge is ignored.
    key_to_cs6("rst_key");
    wr(8'h20, 3'd7, 1'b1, 1'b0, "rst_cmd");
    bus_cycle(1'b1, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, "rst_mid_seq");
    idle(3'd0, "idle_after_rst");
    check("ds_led_events_final", ds_led_events, 1);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
